// File: rtl/ysyx_24080006_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24080006_pkg
// Description : Shared types for the execute stage: MDU request encoding,
//               MDU FSM states and operand helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_24080006_pkg;

  // Operation selector carried in the decoder's MDU request
  typedef enum logic [1:0] {
    OP_MULL = 2'd0,
    OP_MULH = 2'd1,
    OP_DIV  = 2'd2,
    OP_REM  = 2'd3
  } mdu_op_e;

  // Decoder request bundle: {mdu_enable, signed_a, signed_b, mdu_op}
  typedef struct packed {
    logic    mdu_enable;
    logic    signed_a;
    logic    signed_b;
    mdu_op_e mdu_op;
  } mdu_set_t;

  // Iterative MDU control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  // Counter value on the 32nd (final) datapath iteration
  localparam logic [4:0] MDU_LAST_ITER = 5'd31;

  // Two's-complement magnitude of v when it is to be treated as signed
  function automatic logic [31:0] mdu_mag(input logic [31:0] v, input logic is_signed);
    return (is_signed & v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24080006_mdu_step.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24080006_mdu_step
// Description : One radix-2 iteration of the MDU magnitude datapath.
//               div_i=0 : shift-add multiply step  (acc = {hi, multiplier})
//               div_i=1 : restoring divide step    (acc = {rem, quotient})
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24080006_mdu_step (
  input  logic        div_i,
  input  logic [64:0] acc_i,
  input  logic [32:0] operand_i,
  output logic [64:0] acc_o
);

  logic [32:0] sum;
  logic [32:0] hi;
  logic [33:0] srem;
  logic [34:0] diff;
  logic        ge;

  // Single combinational step; both candidate results are formed, mode picks one
  always_comb begin
    // Multiply: conditionally add multiplicand into the upper half, then shift right
    sum  = {1'b0, acc_i[63:32]} + operand_i;
    hi   = acc_i[0] ? sum : {1'b0, acc_i[63:32]};
    // Divide: shift {rem, quo} left by one and trial-subtract the divisor
    srem = acc_i[64:31];
    diff = {1'b0, srem} - {2'b00, operand_i};
    // A non-negative difference is always below 2^33, so both top bits are clear
    ge   = ~(diff[34] | diff[33]);
    if (div_i) begin
      acc_o = {(ge ? diff[32:0] : srem[32:0]), acc_i[30:0], ge};
    end else begin
      acc_o = {1'b0, hi, acc_i[31:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_24080006_mdu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24080006_mdu
// Description : Iterative RV32M multiply/divide unit. Magnitudes are latched at
//               accept, 32 radix-2 iterations run, and the sign is fixed up on
//               the final iteration into a registered result.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24080006_mdu
  import ysyx_24080006_pkg::*;
#(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  mdu_set_t    mdu_set,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  mdu_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        neg_q, neg_d;
  mdu_op_e     op_q, op_d;
  logic [31:0] result_q, result_d;

  logic        accept;
  logic        is_mul;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [64:0] step_acc;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  assign accept    = in_valid & in_ready & mdu_set.mdu_enable & ~flush;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

  ysyx_24080006_mdu_step u_step (
    .div_i     (state_q == DIV),
    .acc_i     (acc_q),
    .operand_i ({1'b0, opnd_q}),
    .acc_o     (step_acc)
  );

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      op_q     <= OP_MULL;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  // Next-state, operand latching, iteration and final sign fix-up
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    op_d     = op_q;
    result_d = result_q;

    is_mul = (mdu_set.mdu_op == OP_MULL) || (mdu_set.mdu_op == OP_MULH);
    sign_a = op_a[31] & mdu_set.signed_a;
    sign_b = op_b[31] & mdu_set.signed_b;
    mag_a  = mdu_mag(op_a, mdu_set.signed_a);
    mag_b  = mdu_mag(op_b, mdu_set.signed_b);

    // Sign-corrected views of the value produced by the final iteration
    prod = neg_q ? (~step_acc[63:0] + 64'd1) : step_acc[63:0];
    quo  = neg_q ? (~step_acc[31:0] + 32'd1) : step_acc[31:0];
    rem  = neg_q ? (~step_acc[63:32] + 32'd1) : step_acc[63:32];

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = mdu_set.mdu_op;
          cnt_d = '0;
          if (is_mul) begin
            neg_d  = sign_a ^ sign_b;
            opnd_d = mag_a;
            acc_d  = {33'd0, mag_b};
            if (ZERO_SKIP && ((op_a == 32'd0) || (op_b == 32'd0))) begin
              result_d = '0;
              state_d  = DONE;
            end else begin
              state_d = MUL;
            end
          end else begin
            // Remainder takes the dividend's sign; quotient the XOR of both
            neg_d  = (mdu_set.mdu_op == OP_REM) ? sign_a : (sign_a ^ sign_b);
            opnd_d = mag_b;
            acc_d  = {33'd0, mag_a};
            if (op_b == 32'd0) begin
              result_d = (mdu_set.mdu_op == OP_DIV) ? 32'hFFFF_FFFF : op_a;
              state_d  = DONE;
            end else begin
              state_d = DIV;
            end
          end
        end
      end
      MUL, DIV: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == MDU_LAST_ITER) begin
          state_d = DONE;
          unique case (op_q)
            OP_MULL: result_d = prod[31:0];
            OP_MULH: result_d = prod[63:32];
            OP_DIV:  result_d = quo;
            default: result_d = rem;
          endcase
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush aborts whatever is in flight, including a pending result
    if (flush) begin
      state_d = IDLE;
    end
  end

endmodule
`default_nettype wire
